// File: rtl/binary_to_gray_recon.sv
// binary_to_gray_recon
//   Turns a thresholded binary pixel stream (0 / 4095) back into a 12-bit grayscale stream.
//   Each output pixel is the count of set pixels in a sliding horizontal window of WIN = 2**LOG2_WIN
//   valid pixels, scaled to 12 bits. The window restarts at every line start by filling all taps
//   with the first pixel of the line (left-edge replicate), so no history leaks between lines.
//
// Parameters
//   LINE_WIDTH  valid pixels per line; the column counter wraps after LINE_WIDTH-1
//   LOG2_WIN    log2 of the window length; legal range 1..6
//
// Ports
//   iCLK    in   1   pixel clock
//   iRST    in   1   asynchronous, active-high reset
//   iDVAL   in   1   input pixel valid, one pixel per cycle while high
//   iDATA   in   12  binary pixel; only iDATA[11] is used
//   oDVAL   out  1   output pixel valid, iDVAL delayed by one cycle
//   oDATA   out  12  reconstructed gray pixel; holds its value while oDVAL is low

module binary_to_gray_recon #(
   parameter int unsigned LINE_WIDTH = 640,
   parameter int unsigned LOG2_WIN   = 3
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iDVAL,
   input  logic [11:0] iDATA,
   output logic        oDVAL,
   output logic [11:0] oDATA
);

   localparam int unsigned WIN   = 1 << LOG2_WIN;
   localparam int unsigned COL_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
   localparam int unsigned SUM_W = LOG2_WIN + 1;
   localparam int unsigned SHIFT = 12 - LOG2_WIN;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);
   localparam logic [SUM_W-1:0] SUM_FULL = SUM_W'(WIN);

   logic [COL_W-1:0] col_q, col_d;
   logic [WIN-1:0]   taps_q, taps_d;    // taps_q[WIN-1] is the oldest pixel
   logic [SUM_W-1:0] sum_q, sum_d;
   logic             dval_q, dval_d;
   logic [11:0]      data_q, data_d;

   logic pix;
   logic oldest;
   logic line_start;
   logic unused_data_lsbs;

   assign pix              = iDATA[11];
   assign oldest           = taps_q[WIN-1];
   assign line_start       = (col_q == '0);
   assign unused_data_lsbs = ^iDATA[10:0];

   always_comb begin
      col_d  = col_q;
      taps_d = taps_q;
      sum_d  = sum_q;
      dval_d = 1'b0;
      data_d = data_q;

      if (iDVAL) begin
         dval_d = 1'b1;

         if (line_start) begin
            // Replicate the first pixel into every tap; those taps then age out like real pixels.
            taps_d = {WIN{pix}};
            sum_d  = pix ? SUM_FULL : '0;
         end else begin
            taps_d = {taps_q[WIN-2:0], pix};
            // sum_q already counts oldest, so this never underflows and never exceeds WIN.
            sum_d  = sum_q + SUM_W'(pix) - SUM_W'(oldest);
         end

         col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;

         // A full window would scale to 4096, so saturate it to full white.
         data_d = (sum_d == SUM_FULL) ? 12'hFFF : (12'(sum_d) << SHIFT);
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         col_q  <= '0;
         taps_q <= '0;
         sum_q  <= '0;
         dval_q <= 1'b0;
         data_q <= '0;
      end else begin
         col_q  <= col_d;
         taps_q <= taps_d;
         sum_q  <= sum_d;
         dval_q <= dval_d;
         data_q <= data_d;
      end
   end

   assign oDVAL = dval_q;
   assign oDATA = data_q;

endmodule

// File: tb/tb_binary_to_gray_recon.sv
// Scoreboard bench for binary_to_gray_recon (WIN = 8, LINE_WIDTH = 16).
// Stimulus pushes the hand-computed output of each pixel into exp_q; the monitor pops one entry per
// oDVAL pulse, checks oDVAL against the previous cycle's iDVAL, and checks that oDATA holds while
// oDVAL is low.

module tb_binary_to_gray_recon;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dval = 1'b0;
   logic [11:0] data = 12'd0;
   logic        odval;
   logic [11:0] odata;

   int n_vec = 0;
   int n_err = 0;
   int exp_q[$];
   int last_exp = 0;

   // Cols 0-3 black, cols 4-15 white.
   int t2_exp [16] = '{0, 0, 0, 0, 512, 1024, 1536, 2048, 2560, 3072, 3584,
                       4095, 4095, 4095, 4095, 4095};
   // Col 0 black, cols 1-15 white.
   int ramp_exp [16] = '{0, 512, 1024, 1536, 2048, 2560, 3072, 3584,
                         4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095};

   binary_to_gray_recon #(
      .LINE_WIDTH (16),
      .LOG2_WIN   (3)
   ) dut (
      .iCLK  (clk),
      .iRST  (rst),
      .iDVAL (dval),
      .iDATA (data),
      .oDVAL (odval),
      .oDATA (odata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Drive one valid pixel and record its expected output.
   task automatic send(input logic [11:0] d, input int e);
      dval = 1'b1;
      data = d;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      dval = 1'b0;
      data = 12'($urandom);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: sample the cycle's inputs at posedge, check the registered outputs at negedge.
   initial begin
      bit prev_dval;
      int e;
      forever begin
         @(posedge clk);
         prev_dval = rst ? 1'b0 : dval;
         if (rst) last_exp = 0;
         @(negedge clk);
         check("odval", int'(odval), int'(prev_dval));
         if (odval) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_output: got oDATA=%0d, required no output (t=%0t)",
                        odata, $time);
            end else begin
               e = exp_q.pop_front();
               check("odata", int'(odata), e);
               last_exp = e;
            end
         end else begin
            check("odata_hold", int'(odata), last_exp);
         end
      end
   end

   initial begin
      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_odval", int'(odval), 0);
      check("reset_odata", int'(odata), 0);
      rst = 1'b0;
      idle(1);

      // Test 1: full white line
      for (int i = 0; i < 16; i++) send(12'hFFF, 4095);
      idle(2);

      // Test 2: black cols 0-3, white cols 4-15
      for (int i = 0; i < 16; i++) send((i < 4) ? 12'h000 : 12'hFFF, t2_exp[i]);
      idle(2);

      // Test 3: white line, then a line starting black
      for (int i = 0; i < 16; i++) send(12'hFFF, 4095);
      for (int i = 0; i < 16; i++) send((i == 0) ? 12'h000 : 12'hFFF, ramp_exp[i]);
      idle(1);

      // Test 4: test 2 with a 3-cycle stall after col 5
      for (int i = 0; i < 16; i++) begin
         send((i < 4) ? 12'h000 : 12'hFFF, t2_exp[i]);
         if (i == 5) idle(3);
      end
      idle(1);

      // Test 5: async reset at col 9 with the window full of ones
      for (int i = 0; i < 10; i++) send(12'hFFF, 4095);
      dval = 1'b0;
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_odval", int'(odval), 0);
      check("async_rst_odata", int'(odata), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 16; i++) send(12'hFFF, 4095);

      // Next line starts 16 valid pixels after release; bit 11 alone counts as white
      for (int i = 0; i < 16; i++) send((i == 0) ? 12'h000 : 12'h800, ramp_exp[i]);

      // Test 6: 12'h7FF is black
      for (int i = 0; i < 16; i++) send(12'h7FF, 0);
      // Replicated white taps age out one at a time
      send(12'hFFF, 4095);
      send(12'h7FF, 3584);
      send(12'h7FF, 3072);
      idle(4);

      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
